// File: rtl/sram_ctrl_param.sv
// Parametrised async-SRAM controller: valid/ready requests, configurable read wait
// and write-pulse width, separate write setup/hold, registered strobes and bus enable.
module sram_ctrl_param #(
  parameter int ADDR_WIDTH = 21,
  parameter int DATA_WIDTH = 8,
  parameter int RD_WAIT    = 2,
  parameter int WR_PULSE   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_rw,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  wr_done,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  inout  wire logic [DATA_WIDTH-1:0] sram_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD
  } state_t;

  localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_PULSE - 1);

  state_t                  state, state_nx;
  logic [3:0]              cnt, cnt_nx;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    drive;
  logic                    accept;
  logic                    ce_nx, oe_nx, we_nx, drive_nx, ready_nx, rvalid_nx, wdone_nx;

  assign accept    = req_valid && req_ready;
  assign sram_data = drive ? wdata : 'z;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nx = req_rw ? S_RD : S_WR_SETUP;
          if (req_rw) cnt_nx = RD_LOAD;
        end
      end
      S_RD: begin
        if (cnt == 4'd0) state_nx = S_IDLE;
        else             cnt_nx   = cnt - 4'd1;
      end
      S_WR_SETUP: begin
        state_nx = S_WR_PULSE;
        cnt_nx   = WR_LOAD;
      end
      S_WR_PULSE: begin
        if (cnt == 4'd0) state_nx = S_WR_HOLD;
        else             cnt_nx   = cnt - 4'd1;
      end
      S_WR_HOLD: state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Strobes and enables are decoded from the next state so they register alongside it.
  always_comb begin
    ce_nx     = (state_nx == S_IDLE);
    oe_nx     = (state_nx != S_RD);
    we_nx     = (state_nx != S_WR_PULSE);
    drive_nx  = (state_nx == S_WR_SETUP) || (state_nx == S_WR_PULSE) || (state_nx == S_WR_HOLD);
    ready_nx  = (state_nx == S_IDLE);
    rvalid_nx = (state == S_RD) && (cnt == 4'd0);
    wdone_nx  = (state == S_WR_HOLD);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      wdata     <= '0;
      drive     <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rd_valid  <= 1'b0;
      wr_done   <= 1'b0;
      rd_data   <= '0;
      sram_addr <= '0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      drive     <= drive_nx;
      req_ready <= ready_nx;
      busy      <= ~ready_nx;
      rd_valid  <= rvalid_nx;
      wr_done   <= wdone_nx;
      sram_ce_n <= ce_nx;
      sram_oe_n <= oe_nx;
      sram_we_n <= we_nx;
      if (accept) begin
        sram_addr <= req_addr;
        wdata     <= req_wdata;
      end
      if (rvalid_nx) rd_data <= sram_data;
    end
  end

endmodule

// File: tb/tb_sram_ctrl_param.sv
// Bench for sram_ctrl_param: default instance for directed cases, swept instance
// for a random read/write stream against a scoreboard; both drive an async-SRAM model.
module tb_sram_ctrl_param;

  localparam int A_AW = 21, A_DW = 8,  A_RW = 2, A_WP = 2;
  localparam int B_AW = 20, B_DW = 16, B_RW = 1, B_WP = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic            a_valid = 1'b0, a_rw = 1'b0;
  logic [A_AW-1:0] a_addr = '0;
  logic [A_DW-1:0] a_wdata = '0;
  logic            a_ready, a_rvalid, a_wdone, a_busy, a_ce, a_oe, a_we;
  logic [A_DW-1:0] a_rdata;
  logic [A_AW-1:0] a_saddr;
  wire  [A_DW-1:0] a_bus;

  logic            b_valid = 1'b0, b_rw = 1'b0;
  logic [B_AW-1:0] b_addr = '0;
  logic [B_DW-1:0] b_wdata = '0;
  logic            b_ready, b_rvalid, b_wdone, b_busy, b_ce, b_oe, b_we;
  logic [B_DW-1:0] b_rdata;
  logic [B_AW-1:0] b_saddr;
  wire  [B_DW-1:0] b_bus;

  sram_ctrl_param #(.ADDR_WIDTH(A_AW), .DATA_WIDTH(A_DW), .RD_WAIT(A_RW), .WR_PULSE(A_WP)) dut_a (
    .clk(clk), .reset_n(reset_n), .req_valid(a_valid), .req_ready(a_ready), .req_rw(a_rw),
    .req_addr(a_addr), .req_wdata(a_wdata), .rd_data(a_rdata), .rd_valid(a_rvalid),
    .wr_done(a_wdone), .busy(a_busy), .sram_addr(a_saddr), .sram_ce_n(a_ce),
    .sram_oe_n(a_oe), .sram_we_n(a_we), .sram_data(a_bus));

  sram_ctrl_param #(.ADDR_WIDTH(B_AW), .DATA_WIDTH(B_DW), .RD_WAIT(B_RW), .WR_PULSE(B_WP)) dut_b (
    .clk(clk), .reset_n(reset_n), .req_valid(b_valid), .req_ready(b_ready), .req_rw(b_rw),
    .req_addr(b_addr), .req_wdata(b_wdata), .rd_data(b_rdata), .rd_valid(b_rvalid),
    .wr_done(b_wdone), .busy(b_busy), .sram_addr(b_saddr), .sram_ce_n(b_ce),
    .sram_oe_n(b_oe), .sram_we_n(b_we), .sram_data(b_bus));

  // Async SRAM models: drive only when selected for read; store while we_n is low.
  logic [A_DW-1:0] mem_a [int];
  logic [B_DW-1:0] mem_b [int];
  logic [A_DW-1:0] a_q = '0;
  logic [B_DW-1:0] b_q = '0;

  assign a_bus = (!a_ce && !a_oe && a_we) ? a_q : 'z;
  assign b_bus = (!b_ce && !b_oe && b_we) ? b_q : 'z;

  always @(negedge clk) begin
    if (mem_a.exists(int'(a_saddr))) a_q = mem_a[int'(a_saddr)];
    else                             a_q = '0;
    if (mem_b.exists(int'(b_saddr))) b_q = mem_b[int'(b_saddr)];
    else                             b_q = '0;
  end

  always @(posedge clk) begin
    if (!a_ce && !a_we) mem_a[int'(a_saddr)] = a_bus;
    if (!b_ce && !b_we) mem_b[int'(b_saddr)] = b_bus;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Per-cycle bus-safety checks, sampled just after each rising edge.
  logic            mon_arm = 1'b0;
  logic            a_rdy_prev = 1'b1;
  logic [A_AW-1:0] a_addr_prev = '0;

  always begin
    @(posedge clk);
    #1;
    if (reset_n && mon_arm) begin
      chk("a_busy_inv",   a_busy, !a_ready);
      chk("a_drive_oe",   dut_a.drive && !a_oe, 0);
      chk("a_we_drive",   !a_we && !dut_a.drive, 0);
      chk("a_pulse_excl", a_rvalid && a_wdone, 0);
      if (!(a_valid && a_rdy_prev)) chk("a_addr_stable", a_saddr, a_addr_prev);
      chk("b_busy_inv",   b_busy, !b_ready);
      chk("b_drive_oe",   dut_b.drive && !b_oe, 0);
      chk("b_we_drive",   !b_we && !dut_b.drive, 0);
      chk("b_pulse_excl", b_rvalid && b_wdone, 0);
    end
    mon_arm     = reset_n;
    a_rdy_prev  = a_ready;
    a_addr_prev = a_saddr;
  end

  logic tr_we [64];
  logic tr_drv[64];
  logic tr_oe [64];

  task automatic a_op(input logic rw, input logic [A_AW-1:0] addr, input logic [A_DW-1:0] wd,
                      output int lat, output logic [A_DW-1:0] rd);
    int n;
    n = 0;
    @(negedge clk);
    while (!a_ready && n < 50) begin @(negedge clk); n++; end
    chk("a_ready_wait", a_ready, 1);
    a_valid = 1'b1; a_rw = rw; a_addr = addr; a_wdata = wd;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) a_valid = 1'b0;
      if (lat < 64) begin tr_we[lat] = a_we; tr_drv[lat] = dut_a.drive; tr_oe[lat] = a_oe; end
    end while (!(rw ? a_rvalid : a_wdone) && lat < 50);
    rd = a_rdata;
  endtask

  task automatic b_op(input logic rw, input logic [B_AW-1:0] addr, input logic [B_DW-1:0] wd,
                      output int lat, output logic [B_DW-1:0] rd);
    int n;
    n = 0;
    @(negedge clk);
    while (!b_ready && n < 50) begin @(negedge clk); n++; end
    chk("b_ready_wait", b_ready, 1);
    b_valid = 1'b1; b_rw = rw; b_addr = addr; b_wdata = wd;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) b_valid = 1'b0;
    end while (!(rw ? b_rvalid : b_wdone) && lat < 50);
    rd = b_rdata;
  endtask

  initial begin
    int              lat, cyc, got, last, issued, inflight, wd_at, rv_at;
    logic [A_DW-1:0] ard;
    logic [B_DW-1:0] brd, bexp;
    logic [B_AW-1:0] pool [16];
    logic [B_DW-1:0] sb [int];
    logic [A_DW-1:0] b2b_exp [3];

    mem_a[32'h2A] = 8'h5C;

    // Reset values while reset_n is held low
    repeat (3) @(negedge clk);
    chk("rst_ready", a_ready, 1);   chk("rst_busy", a_busy, 0);
    chk("rst_rvalid", a_rvalid, 0); chk("rst_wdone", a_wdone, 0);
    chk("rst_rdata", a_rdata, 0);   chk("rst_saddr", a_saddr, 0);
    chk("rst_ce", a_ce, 1); chk("rst_oe", a_oe, 1); chk("rst_we", a_we, 1);
    chk("rst_drive", dut_a.drive, 0);
    chk("rst_b_ready", b_ready, 1); chk("rst_b_drive", dut_b.drive, 0);

    // Request presented for the first edge after release is accepted there
    reset_n = 1'b1; a_valid = 1'b1; a_rw = 1'b1; a_addr = 21'h2A;
    @(negedge clk);
    a_valid = 1'b0;
    chk("first_acc_busy", a_busy, 1);
    chk("first_acc_addr", a_saddr, 21'h2A);
    lat = 1;
    while (!a_rvalid && lat < 50) begin @(negedge clk); lat++; end
    chk("first_rd_lat", lat, A_RW + 1);
    chk("first_rd_data", a_rdata, 8'h5C);

    // Single write then read
    a_op(1'b0, 21'h15A3, 8'hC7, lat, ard);
    chk("wr_lat", lat, A_WP + 3);
    for (int k = 1; k <= A_WP + 3; k++) begin
      chk($sformatf("wr_we_c%0d", k), tr_we[k], !(k >= 2 && k <= A_WP + 1));
      chk($sformatf("wr_drv_c%0d", k), tr_drv[k], k <= A_WP + 2);
    end
    a_op(1'b1, 21'h15A3, 8'h00, lat, ard);
    chk("rd_lat", lat, A_RW + 1);
    chk("rd_data", ard, 8'hC7);
    for (int k = 1; k <= A_RW + 1; k++) begin
      chk($sformatf("rd_oe_c%0d", k), tr_oe[k], k > A_RW);
      chk($sformatf("rd_drv_c%0d", k), tr_drv[k], 0);
    end

    // Back-to-back reads with req_valid held
    mem_a[0] = 8'h11; mem_a[1] = 8'h22; mem_a[2] = 8'h33;
    b2b_exp[0] = 8'h11; b2b_exp[1] = 8'h22; b2b_exp[2] = 8'h33;
    @(negedge clk);
    cyc = 0;
    while (!a_ready && cyc < 50) begin @(negedge clk); cyc++; end
    a_valid = 1'b1; a_rw = 1'b1; a_addr = '0;
    issued = 1; inflight = 0; got = 0; last = 0; cyc = 0;
    while (got < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (!a_oe) chk("b2b_addr", a_saddr, inflight);
      if (a_rvalid) begin
        chk("b2b_data", a_rdata, b2b_exp[got]);
        if (got > 0) chk("b2b_gap", cyc - last, A_RW + 1);
        else         chk("b2b_first", cyc, A_RW + 1);
        last = cyc;
        got++;
      end
      if (a_ready) begin
        if (issued < 3) begin a_addr = 21'(issued); inflight = issued; issued++; end
        else a_valid = 1'b0;
      end
    end
    a_valid = 1'b0;
    chk("b2b_count", got, 3);

    // Write immediately followed by a read; inputs scrambled while busy
    @(negedge clk);
    cyc = 0;
    while (!a_ready && cyc < 50) begin @(negedge clk); cyc++; end
    a_valid = 1'b1; a_rw = 1'b0; a_addr = 21'h0ABCD; a_wdata = 8'h96;
    cyc = 0; wd_at = 0; rv_at = 0;
    while (rv_at == 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin a_addr = 21'h1FFFFF; a_wdata = 8'h00; end
      if (a_wdone) begin
        wd_at = cyc;
        chk("ta_idle_drive", dut_a.drive, 0);
        chk("ta_idle_oe", a_oe, 1);
        chk("ta_idle_ready", a_ready, 1);
        a_rw = 1'b1; a_addr = 21'h0ABCD;
      end
      if (a_rvalid) begin rv_at = cyc; a_valid = 1'b0; end
    end
    a_valid = 1'b0;
    chk("ta_wdone_at", wd_at, A_WP + 3);
    chk("ta_rvalid_at", rv_at, A_WP + 3 + A_RW + 1);
    chk("ta_rdata", a_rdata, 8'h96);

    // Random stream on the swept instance against a scoreboard
    for (int i = 0; i < 16; i++) pool[i] = B_AW'($urandom);
    for (int i = 0; i < 1000; i++) begin
      logic            rw;
      logic [B_AW-1:0] ad;
      logic [B_DW-1:0] wd;
      rw = 1'($urandom_range(0, 1));
      ad = pool[$urandom_range(0, 15)];
      wd = B_DW'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      b_op(rw, ad, wd, lat, brd);
      if (rw) begin
        bexp = sb.exists(int'(ad)) ? sb[int'(ad)] : '0;
        chk("sw_rd_data", brd, bexp);
        chk("sw_rd_lat", lat, B_RW + 1);
      end else begin
        sb[int'(ad)] = wd;
        chk("sw_wr_lat", lat, B_WP + 3);
      end
    end

    // Reset asserted during the second write-pulse cycle
    @(negedge clk);
    cyc = 0;
    while (!a_ready && cyc < 50) begin @(negedge clk); cyc++; end
    a_valid = 1'b1; a_rw = 1'b0; a_addr = 21'h0F0; a_wdata = 8'h3C;
    @(posedge clk);
    #1 a_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 chk("mr_we_before", a_we, 0);
    #1 reset_n = 1'b0;
    #1;
    chk("mr_we", a_we, 1);       chk("mr_oe", a_oe, 1);     chk("mr_ce", a_ce, 1);
    chk("mr_drive", dut_a.drive, 0);
    chk("mr_ready", a_ready, 1); chk("mr_busy", a_busy, 0); chk("mr_wdone", a_wdone, 0);
    chk("mr_saddr", a_saddr, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < A_WP + 4; k++) begin
      @(negedge clk);
      chk("mr_no_wdone", a_wdone, 0);
      chk("mr_ready_after", a_ready, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
